// File: rtl/fetch_pkg.sv
// Shared fetch-side definitions: buffer state encodings and default word geometry.
package fetch_pkg;

    localparam int DEF_XLEN    = 32;
    localparam int DEF_EXT_BIT = 31;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        WAIT_IMM = 2'd1,
        FULL     = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async active-low clear; only built when
// IF_ID_STALL_CNT_EN is defined (it has no user otherwise).
`ifdef IF_ID_STALL_CNT_EN
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule
`endif

// File: rtl/if_id_buffer.sv
// Fetch-to-decode buffer assembling opcode(+immediate) instructions, with flush.
// Optional IF_ID_STALL_CNT_EN adds a saturating backpressure stall counter output.
module if_id_buffer
    import fetch_pkg::*;
#(
    parameter int XLEN    = fetch_pkg::DEF_XLEN,
    parameter int EXT_BIT = fetch_pkg::DEF_EXT_BIT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_word,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_int,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_imm,
    output logic            out_has_imm,
    output logic [XLEN-1:0] out_pc,
    output logic            out_int
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [15:0]     stall_cnt
`endif
);

    state_t state;
    state_t nxt;
    logic   acc;
    logic   load_first;
    logic   load_imm;
    logic   word_ext;

    assign acc       = in_valid & in_ready;
    assign out_valid = (state == FULL);
    assign word_ext  = in_word[EXT_BIT];

    // rst gates in_ready so fetch sees no acceptance while reset is held.
    always_comb begin
        in_ready = 1'b0;
        if (rst && !flush) begin
            case (state)
                EMPTY:    in_ready = 1'b1;
                WAIT_IMM: in_ready = 1'b1;
                FULL:     in_ready = out_ready;
                default:  in_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        nxt        = state;
        load_first = 1'b0;
        load_imm   = 1'b0;
        if (flush) begin
            nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        load_first = 1'b1;
                        nxt        = word_ext ? WAIT_IMM : FULL;
                    end
                end
                WAIT_IMM: begin
                    if (acc) begin
                        load_imm = 1'b1;
                        nxt      = FULL;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        if (acc) begin
                            load_first = 1'b1;
                            nxt        = word_ext ? WAIT_IMM : FULL;
                        end else begin
                            nxt = EMPTY;
                        end
                    end
                end
                default: nxt = EMPTY;
            endcase
        end
    end

    // A new first word always clears the immediate; WAIT_IMM fills it in later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= EMPTY;
            out_instr   <= '0;
            out_imm     <= '0;
            out_has_imm <= 1'b0;
            out_pc      <= '0;
            out_int     <= 1'b0;
        end else begin
            state <= nxt;
            if (load_first) begin
                out_instr   <= in_word;
                out_pc      <= in_pc;
                out_int     <= in_int;
                out_has_imm <= word_ext;
                out_imm     <= '0;
            end
            if (load_imm) begin
                out_imm <= in_word;
            end
        end
    end

`ifdef IF_ID_STALL_CNT_EN
    logic stall_en;

    assign stall_en = (state == FULL) & ~out_ready & ~flush;

    sat_counter #(
        .W(16)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (stall_en),
        .cnt (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed testbench for if_id_buffer: plain/extended assembly, streaming,
// backpressure, flush and asynchronous reset.
`timescale 1ns/1ps
module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic [31:0] in_pc;
    logic        in_int;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_imm;
    logic        out_has_imm;
    logic [31:0] out_pc;
    logic        out_int;
`ifdef IF_ID_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_id_buffer #(.XLEN(32), .EXT_BIT(31)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_word     (in_word),
        .in_pc       (in_pc),
        .in_int      (in_int),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_imm     (out_imm),
        .out_has_imm (out_has_imm),
        .out_pc      (out_pc),
        .out_int     (out_int)
`ifdef IF_ID_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc, input logic irq);
        in_valid = v;
        in_word  = w;
        in_pc    = pc;
        in_int   = irq;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 32'hFFFF_FFFF, 32'h4, 1'b1);
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0h exp=0", in_ready); end
        checks++; if (out_instr !== 32'h0 || out_pc !== 32'h0 || out_imm !== 32'h0) begin failures++; $display("FAIL reset_data instr=%0h pc=%0h imm=%0h exp=0", out_instr, out_pc, out_imm); end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%0h exp=1", in_ready); end
    endtask

    task automatic test_plain();
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_1234, 32'h100, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL plain_valid got=%0h exp=1", out_valid); end
        checks++; if (out_instr !== 32'h1234) begin failures++; $display("FAIL plain_instr got=%0h exp=1234", out_instr); end
        checks++; if (out_has_imm !== 1'b0 || out_imm !== 32'h0) begin failures++; $display("FAIL plain_imm has=%0h imm=%0h exp=0/0", out_has_imm, out_imm); end
        checks++; if (out_pc !== 32'h100) begin failures++; $display("FAIL plain_pc got=%0h exp=100", out_pc); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL plain_drain got=%0h exp=0", out_valid); end
    endtask

    task automatic test_extended();
        out_ready = 1'b0;
        drive(1'b1, 32'h8000_0005, 32'h200, 1'b0);
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ext_early_valid got=%0h exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ext_wait_ready got=%0h exp=1", in_ready); end
        drive(1'b1, 32'hDEAD_BEEF, 32'h999, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ext_valid got=%0h exp=1", out_valid); end
        checks++; if (out_has_imm !== 1'b1 || out_imm !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ext_imm has=%0h imm=%0h exp=1/deadbeef", out_has_imm, out_imm); end
        checks++; if (out_pc !== 32'h200 || out_instr !== 32'h8000_0005 || out_int !== 1'b0) begin failures++; $display("FAIL ext_first pc=%0h instr=%0h int=%0h exp=200/80000005/0", out_pc, out_instr, out_int); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ext_drain got=%0h exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3] = '{32'h1, 32'h2, 32'h3};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, words[i], 32'h300 + 32'(4 * i), 1'b0);
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%0h exp=1", i, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1 || out_instr !== words[i]) begin failures++; $display("FAIL b2b_out[%0d] valid=%0h instr=%0h exp=1/%0h", i, out_valid, out_instr, words[i]); end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0h exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'h55, 32'h400, 1'b0);
        step();
        drive(1'b1, 32'h66, 32'h404, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%0h exp=0", i, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1 || out_instr !== 32'h55 || out_pc !== 32'h400) begin failures++; $display("FAIL bp_hold[%0d] valid=%0h instr=%0h pc=%0h exp=1/55/400", i, out_valid, out_instr, out_pc); end
        end
`ifdef IF_ID_STALL_CNT_EN
        checks++; if (stall_cnt !== 16'd3) begin failures++; $display("FAIL bp_stall_cnt got=%0d exp=3", stall_cnt); end
`endif
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || out_instr !== 32'h66) begin failures++; $display("FAIL bp_release valid=%0h instr=%0h exp=1/66", out_valid, out_instr); end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0h exp=0", out_valid); end
`ifdef IF_ID_STALL_CNT_EN
        checks++; if (stall_cnt !== 16'd3) begin failures++; $display("FAIL bp_stall_keep got=%0d exp=3", stall_cnt); end
`endif
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'h8000_0001, 32'h500, 1'b0);
        step();
        flush = 1'b1;
        drive(1'b1, 32'h99, 32'h504, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0h exp=0", in_ready); end
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got=%0h exp=0", out_valid); end
        drive(1'b1, 32'h7, 32'h600, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_instr !== 32'h7 || out_pc !== 32'h600) begin failures++; $display("FAIL flush_next valid=%0h instr=%0h pc=%0h exp=1/7/600", out_valid, out_instr, out_pc); end
        checks++; if (out_has_imm !== 1'b0 || out_imm !== 32'h0) begin failures++; $display("FAIL flush_next_imm has=%0h imm=%0h exp=0/0", out_has_imm, out_imm); end
        out_ready = 1'b1;
        flush = 1'b1;
        drive(1'b1, 32'h8, 32'h604, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_full_ready got=%0h exp=0", in_ready); end
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_full_empty got=%0h exp=0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 32'h700, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_int !== 1'b1) begin failures++; $display("FAIL ar_pre valid=%0h int=%0h exp=1/1", out_valid, out_int); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_int !== 1'b0) begin failures++; $display("FAIL ar_now valid=%0h int=%0h exp=0/0", out_valid, out_int); end
        checks++; if (out_instr !== 32'h0 || out_pc !== 32'h0 || out_imm !== 32'h0 || out_has_imm !== 1'b0) begin failures++; $display("FAIL ar_data instr=%0h pc=%0h imm=%0h has=%0h exp=0", out_instr, out_pc, out_imm, out_has_imm); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ar_ready got=%0h exp=0", in_ready); end
`ifdef IF_ID_STALL_CNT_EN
        checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL ar_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
        step();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL ar_held ready=%0h valid=%0h exp=0/0", in_ready, out_valid); end
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL ar_release ready=%0h valid=%0h exp=1/0", in_ready, out_valid); end
    endtask

    initial begin
        test_reset();
        test_plain();
        test_extended();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
